uart_tx_slave: RTL and testbench
================================

Name: uart_tx_slave

Overview:
Memory-mapped UART transmitter that sits on the core's data-RAM bus as a responder. The bus decoder routes accesses in its address window here instead of to RAM. The block answers the core's chip-enable, write-enable, address and write-data signals, and returns read data in the same cycle. Written bytes go into a small TX FIFO and are serialized 8N1, LSB first, on tx_out.

Parameters:
ADDR_WIDTH, 32, bus address width
DATA_WIDTH, 32, bus data width
BASE_ADDR, 32'h2000_0000, window base; window is BASE_ADDR..BASE_ADDR+0xF
CLK_DIV, 16'd4, reset value of BAUD_DIV (clocks per bit)
FIFO_DEPTH, 8, TX FIFO entries; power of 2, at least 2

Ports:
clk_in  input  1  clock, rising edge
reset_in  input  1  asynchronous, active-low reset
ram_ce_in  input  1  bus access valid
ram_we_in  input  1  1 = write, 0 = read
ram_addr_in  input  ADDR_WIDTH  byte address
ram_wdata_in  input  DATA_WIDTH  write data
ram_rdata_out  output  DATA_WIDTH  read data, combinational
tx_out  output  1  serial line, idle high
tx_busy_out  output  1  high while a frame is on the line or the FIFO is non-empty

Behaviour:
- Decode: sel = ram_ce_in && ram_addr_in[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]. Register offset = ram_addr_in[3:2].
- Register map:
  - 0x0 TXDATA: write pushes wdata[7:0]. Reads return 0.
  - 0x4 STATUS, read-only except bit3:
    - bit0 busy (frame in progress)
    - bit1 fifo_full
    - bit2 fifo_empty
    - bit3 overflow, sticky; writing 1 to bit3 clears it
    - bits[7:4] fifo count (saturates at 15)
    - all other bits 0
  - 0x8 BAUD_DIV: bits[15:0] read/write; upper bits read 0.
  - 0xC: reads 0, writes ignored.
- Reads: ram_rdata_out = selected register when sel && !ram_we_in, else 0. There are no wait states and no read side effects.
- Writes: take effect at the rising edge where sel && ram_we_in.
- FIFO push to a full FIFO: the byte is dropped and overflow is set. Fullness is judged before any same-cycle pop, so a push while full is dropped even if a pop happens in that cycle.
- Push and pop in the same cycle on a non-full, non-empty FIFO: count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Reset (async assert, sync release):
  - FIFO empty, overflow 0, BAUD_DIV = CLK_DIV
  - FSM in IDLE, tx_out = 1, tx_busy_out = 0, ram_rdata_out follows the decode (0 when idle bus)
  - Reset mid-frame aborts the frame; the line returns high immediately.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx_out = 1. If the FIFO is non-empty: pop, load the shift register, latch bit_len = max(BAUD_DIV, 1), clear the bit counter, go to START.
  - START: tx_out = 0 for bit_len clocks.
  - DATA: tx_out = shift[0] for bit_len clocks per bit, shifting right after each bit. 8 bits, tracked by a 3-bit index; after index 7, go to STOP.
  - STOP: tx_out = 1 for bit_len clocks, then IDLE.
- IDLE does not pop in the same edge it is entered. A full frame is therefore 10*bit_len clocks, plus 1 idle clock between back-to-back frames.
- Latency: a TXDATA write at edge E0 into an empty FIFO with an idle FSM gives tx_out low from edge E1.
- BAUD_DIV writes during a frame do not affect that frame; they apply from the next frame start. BAUD_DIV = 0 behaves as 1.
- tx_busy_out = (state != IDLE) || !fifo_empty. It is registered-state-derived and is not a combinational function of the bus.
- Accesses with ram_ce_in = 0 or outside the window have no effect.

Test Plan:
- Reset, then read 0x2000_0004 -> rdata = 0x0000_0004 (empty). Read 0x2000_0008 -> 0x0000_0004. tx_out = 1, tx_busy_out = 0.
- Write 0x55 to 0x2000_0000 with BAUD_DIV = 4 -> from edge E1, tx_out holds each level for 4 clocks: 0, 1,0,1,0,1,0,1,0, 1. That is 40 clocks total, then idle high. Busy bit set during the frame.
- Write 9 bytes back-to-back while the first frame is starting -> count peaks at 8. The 9th write while full is dropped and STATUS bit3 = 1. Write 0x8 to 0x2000_0004 -> bit3 clears. Exactly 8 or 9 frames go out depending on the pop timing check; the bench computes the expected count from the full-before-pop rule.
- Write BAUD_DIV = 2 mid-frame (frame at 4) -> current frame keeps 4-clock bits; next frame uses 2-clock bits. Write BAUD_DIV = 0 -> frame uses 1-clock bits.
- Assert reset_in = 0 during DATA bit 3 -> tx_out = 1 and FIFO empty asynchronously. After release, no residual frame appears.
- Access 0x2000_0010 and 0x2000_000C, and write with ram_ce_in = 0 -> rdata = 0, no FIFO push, STATUS unchanged.

Source files
------------

// File: rtl/uart_tx_slave.sv
// uart_tx_slave: memory-mapped 8N1 UART transmitter that answers the core's
// data-RAM bus inside a 16-byte window. Written bytes are queued in a small
// FIFO and shifted out LSB first on tx_out; reads are combinational.
module uart_tx_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h2000_0000,
  parameter logic [15:0]           CLK_DIV    = 16'd4,
  parameter int                    FIFO_DEPTH = 8
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  ram_ce_in,
  input  logic                  ram_we_in,
  input  logic [ADDR_WIDTH-1:0] ram_addr_in,
  input  logic [DATA_WIDTH-1:0] ram_wdata_in,
  output logic [DATA_WIDTH-1:0] ram_rdata_out,
  output logic                  tx_out,
  output logic                  tx_busy_out
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Bus decode
  logic                  w_sel;
  logic                  w_rd;
  logic                  w_wr;
  logic [1:0]            w_off;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [7:0]            w_fifo_byte;
  logic [3:0]            w_cnt_sat;
  logic [DATA_WIDTH-1:0] w_status;
  logic                  w_bit_end;
  logic                  w_unused;

  // FIFO storage and bookkeeping
  logic [7:0]            r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_ovf;
  logic [15:0]           r_baud_div;

  // Transmitter
  state_t                r_state;
  logic                  r_tx;
  logic [7:0]            r_shift;
  logic [15:0]           r_bit_len;
  logic [15:0]           r_clk_cnt;
  logic [2:0]            r_bit_idx;

  assign w_sel      = ram_ce_in && (ram_addr_in[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
  assign w_rd       = w_sel && !ram_we_in;
  assign w_wr       = w_sel && ram_we_in;
  assign w_off      = ram_addr_in[3:2];
  assign w_full     = (r_count == DEPTH_C);
  assign w_empty    = (r_count == {CNT_W{1'b0}});
  // Fullness is judged on the pre-edge count, so a same-cycle pop never frees room.
  assign w_push_req = w_wr && (w_off == 2'd0);
  assign w_push     = w_push_req && !w_full;
  assign w_pop      = (r_state == ST_IDLE) && !w_empty;
  assign w_fifo_byte = r_mem[r_rd_ptr];
  assign w_cnt_sat  = (32'(r_count) > 32'd15) ? 4'hF : 4'(r_count);
  assign w_bit_end  = (r_clk_cnt == (r_bit_len - 16'd1));

  assign tx_out      = r_tx;
  assign tx_busy_out = (r_state != ST_IDLE) || !w_empty;

  // Address LSBs and upper write-data bits carry no meaning for this block.
  assign w_unused = ^{ram_wdata_in[DATA_WIDTH-1:16], ram_addr_in[1:0]};

  // Assemble the STATUS word from registered state.
  always_comb begin
    w_status      = {DATA_WIDTH{1'b0}};
    w_status[0]   = (r_state != ST_IDLE);
    w_status[1]   = w_full;
    w_status[2]   = w_empty;
    w_status[3]   = r_ovf;
    w_status[7:4] = w_cnt_sat;
  end

  // Combinational read mux; zero whenever the access is not a read of this window.
  always_comb begin
    ram_rdata_out = {DATA_WIDTH{1'b0}};
    if (w_rd) begin
      case (w_off)
        2'd1:    ram_rdata_out = w_status;
        2'd2:    ram_rdata_out = {{(DATA_WIDTH-16){1'b0}}, r_baud_div};
        default: ram_rdata_out = {DATA_WIDTH{1'b0}};
      endcase
    end else begin
      ram_rdata_out = {DATA_WIDTH{1'b0}};
    end
  end

  // FIFO data array; contents are don't-care while the count says empty.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= ram_wdata_in[7:0];
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag (write-1-to-clear) and the baud divisor register.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_ovf      <= 1'b0;
      r_baud_div <= CLK_DIV;
    end else begin
      if (w_push_req && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_wr && (w_off == 2'd1) && ram_wdata_in[3]) begin
        r_ovf <= 1'b0;
      end
      if (w_wr && (w_off == 2'd2)) begin
        r_baud_div <= ram_wdata_in[15:0];
      end
    end
  end

  // Frame serializer: bit length is latched at frame start so divisor writes
  // only take effect on the next frame; a divisor of 0 runs as 1.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state   <= ST_IDLE;
      r_tx      <= 1'b1;
      r_shift   <= 8'h00;
      r_bit_len <= 16'd1;
      r_clk_cnt <= 16'd0;
      r_bit_idx <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= w_fifo_byte;
            r_bit_len <= (r_baud_div == 16'd0) ? 16'd1 : r_baud_div;
            r_clk_cnt <= 16'd0;
            r_bit_idx <= 3'd0;
            r_tx      <= 1'b0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_clk_cnt <= 16'd0;
            r_tx      <= r_shift[0];
            r_state   <= ST_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= 16'd0;
            r_shift   <= {1'b0, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_clk_cnt <= 16'd0;
            r_tx      <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_slave.sv
// Self-checking bench for uart_tx_slave: directed bus accesses with a frame
// scoreboard; a line monitor decodes every frame and compares it to the queue.
module tb_uart_tx_slave;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int          DEPTH = 8;

  typedef struct {
    logic [7:0] data;
    int         bitlen;
  } frame_t;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        ram_ce_in;
  logic        ram_we_in;
  logic [31:0] ram_addr_in;
  logic [31:0] ram_wdata_in;
  logic [31:0] ram_rdata_out;
  logic        tx_out;
  logic        tx_busy_out;

  frame_t sb_q[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     pushed = 0;
  int     started = 0;
  int     tb_baud = 4;
  logic   model_ovf = 1'b0;
  logic   mon_active = 1'b0;

  uart_tx_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .BASE_ADDR (BASE),
    .CLK_DIV   (16'd4),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .ram_ce_in    (ram_ce_in),
    .ram_we_in    (ram_we_in),
    .ram_addr_in  (ram_addr_in),
    .ram_wdata_in (ram_wdata_in),
    .ram_rdata_out(ram_rdata_out),
    .tx_out       (tx_out),
    .tx_busy_out  (tx_busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input logic busy, input int cnt, input logic ovf);
    logic [31:0] s;
    s      = 32'h0;
    s[0]   = busy;
    s[1]   = (cnt == DEPTH);
    s[2]   = (cnt == 0);
    s[3]   = ovf;
    s[7:4] = (cnt > 15) ? 4'hF : 4'(cnt);
    return s;
  endfunction

  // Bus write; the reference model decides acceptance on the pre-edge FIFO
  // occupancy (accepted pushes minus frames whose start bit has been seen).
  task automatic wr(input logic ce, input logic [31:0] addr, input logic [31:0] data);
    frame_t f;
    @(negedge clk_in);
    #1;
    ram_ce_in    = ce;
    ram_we_in    = 1'b1;
    ram_addr_in  = addr;
    ram_wdata_in = data;
    if (ce && (addr[31:4] == BASE[31:4])) begin
      case (addr[3:2])
        2'd0: begin
          if ((pushed - started) >= DEPTH) begin
            model_ovf = 1'b1;
          end else begin
            f.data   = data[7:0];
            f.bitlen = (tb_baud == 0) ? 1 : tb_baud;
            sb_q.push_back(f);
            pushed++;
          end
        end
        2'd1: if (data[3]) model_ovf = 1'b0;
        2'd2: tb_baud = int'(data[15:0]);
        default: ;
      endcase
    end
    #1;
    chk("rdata_during_write", ram_rdata_out, 32'h0);
    @(posedge clk_in);
    #1;
    ram_ce_in = 1'b0;
    ram_we_in = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] val);
    @(negedge clk_in);
    #1;
    ram_ce_in   = 1'b1;
    ram_we_in   = 1'b0;
    ram_addr_in = addr;
    #1;
    val       = ram_rdata_out;
    ram_ce_in = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int cyc;
    cyc = 0;
    while ((sb_q.size() != 0 || mon_active || tx_busy_out) && cyc < 3000) begin
      @(negedge clk_in);
      #1;
      cyc++;
    end
    chk({tag, "_drain_in_time"}, 32'(cyc < 3000), 32'd1);
    chk({tag, "_frames_sent"}, 32'(started), 32'(pushed));
  endtask

  // Line monitor: aligns on each start bit and checks every clock of the frame.
  initial begin : monitor
    logic       prev;
    logic       ok;
    logic       aborted;
    logic       exp_bit;
    logic [7:0] rx;
    int         len;
    int         idx;
    frame_t     f;
    prev = 1'b1;
    forever begin
      @(negedge clk_in);
      if (!reset_in) begin
        prev       = 1'b1;
        mon_active = 1'b0;
      end else if (prev && !tx_out) begin
        started++;
        n_vec++;
        assert (sb_q.size() > 0) else begin
          n_err++;
          $error("FAIL unexpected_frame: observed start bit, expected idle line");
        end
        if (sb_q.size() > 0) begin
          f          = sb_q.pop_front();
          len        = f.bitlen;
          mon_active = 1'b1;
          ok         = 1'b1;
          aborted    = 1'b0;
          rx         = 8'h00;
          for (int k = 1; k < 10 * len; k++) begin
            @(negedge clk_in);
            if (!reset_in) begin
              aborted = 1'b1;
              break;
            end
            idx     = k / len;
            exp_bit = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : f.data[idx-1];
            if (idx >= 1 && idx <= 8 && (k % len) == 0) rx[idx-1] = tx_out;
            if (tx_out !== exp_bit) ok = 1'b0;
          end
          if (!aborted) begin
            n_vec++;
            assert (ok === 1'b1) else begin
              n_err++;
              $error("FAIL frame: observed byte 0x%02h expected 0x%02h at %0d clocks/bit (waveform deviates)",
                     rx, f.data, len);
            end
          end
          mon_active = 1'b0;
          prev       = 1'b1;
        end else begin
          prev = 1'b0;
        end
      end else begin
        prev = tx_out;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    logic [31:0] v;
    reset_in     = 1'b0;
    ram_ce_in    = 1'b0;
    ram_we_in    = 1'b0;
    ram_addr_in  = 32'h0;
    ram_wdata_in = 32'h0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_tx_high", 32'(tx_out), 32'd1);
    chk("reset_busy_low", 32'(tx_busy_out), 32'd0);
    @(negedge clk_in);
    reset_in = 1'b1;

    // Reset state
    rd(BASE + 32'h4, v);  chk("status_after_reset", v, exp_status(1'b0, 0, 1'b0));
    rd(BASE + 32'h8, v);  chk("baud_after_reset", v, 32'h0000_0004);
    rd(BASE + 32'h0, v);  chk("txdata_reads_zero", v, 32'h0);
    chk("idle_tx", 32'(tx_out), 32'd1);
    chk("idle_busy", 32'(tx_busy_out), 32'd0);

    // Single frame 0x55 at 4 clocks/bit, with start-bit latency check
    wr(1'b1, BASE, 32'h0000_0055);
    @(negedge clk_in);
    chk("latency_tx_still_high", 32'(tx_out), 32'd1);
    chk("busy_after_push", 32'(tx_busy_out), 32'd1);
    @(negedge clk_in);
    chk("latency_start_bit", 32'(tx_out), 32'd0);
    rd(BASE + 32'h4, v);  chk("status_mid_frame", v, exp_status(1'b1, pushed - started, model_ovf));
    wait_drain("single");

    // Burst of ten writes: the first starts a frame, the rest fill the FIFO
    wr(1'b1, BASE, 32'h0000_00C1);
    for (int i = 0; i < 9; i++) begin
      wr(1'b1, BASE, 32'($urandom_range(0, 255)));
    end
    rd(BASE + 32'h4, v);  chk("status_full_ovf", v, exp_status(1'b1, pushed - started, model_ovf));
    chk("status_full_ovf_bit3", 32'(v[3]), 32'd1);
    wr(1'b1, BASE + 32'h4, 32'h0000_0008);
    rd(BASE + 32'h4, v);  chk("status_ovf_cleared", v, exp_status(1'b1, pushed - started, model_ovf));
    wait_drain("burst");

    // Divisor change mid-frame, then divisor 0
    wr(1'b1, BASE, 32'h0000_00A3);
    repeat (10) @(posedge clk_in);
    wr(1'b1, BASE + 32'h8, 32'h0000_0002);
    rd(BASE + 32'h8, v);  chk("baud_readback_2", v, 32'h0000_0002);
    wr(1'b1, BASE, 32'h0000_003C);
    wait_drain("baud_change");
    wr(1'b1, BASE + 32'h8, 32'h0000_0000);
    wr(1'b1, BASE, 32'h0000_0096);
    wait_drain("baud_zero");
    rd(BASE + 32'h8, v);  chk("baud_readback_0", v, 32'h0);

    // Accesses that must have no effect
    rd(BASE + 32'h10, v); chk("read_outside_window", v, 32'h0);
    rd(BASE + 32'hC, v);  chk("read_reserved", v, 32'h0);
    @(negedge clk_in);
    ram_ce_in   = 1'b0;
    ram_we_in   = 1'b0;
    ram_addr_in = BASE + 32'h4;
    #1;
    chk("read_ce_low", ram_rdata_out, 32'h0);
    wr(1'b0, BASE, 32'h0000_00AB);
    wr(1'b1, BASE + 32'h10, 32'h0000_0077);
    wr(1'b1, BASE + 32'hC, 32'hFFFF_FFFF);
    wr(1'b1, BASE + 32'h18, 32'h0000_1234);
    wr(1'b0, BASE + 32'h8, 32'h0000_0005);
    repeat (20) @(posedge clk_in);
    #1;
    chk("no_push_frames", 32'(started), 32'(pushed));
    chk("no_push_busy", 32'(tx_busy_out), 32'd0);
    rd(BASE + 32'h4, v);  chk("status_unchanged", v, exp_status(1'b0, 0, model_ovf));
    rd(BASE + 32'h8, v);  chk("baud_unchanged", v, 32'(tb_baud));

    // Reset during data bit 3 of 0xF0 (a low bit) with a second byte queued
    wr(1'b1, BASE + 32'h8, 32'h0000_0004);
    wr(1'b1, BASE, 32'h0000_00F0);
    wr(1'b1, BASE, 32'h0000_000F);
    repeat (17) @(posedge clk_in);
    #3;
    chk("pre_reset_data_bit3", 32'(tx_out), 32'd0);
    reset_in = 1'b0;
    #1;
    chk("reset_abort_tx_high", 32'(tx_out), 32'd1);
    chk("reset_abort_busy_low", 32'(tx_busy_out), 32'd0);
    ram_ce_in   = 1'b1;
    ram_we_in   = 1'b0;
    ram_addr_in = BASE + 32'h4;
    #1;
    chk("reset_abort_fifo_empty", ram_rdata_out, exp_status(1'b0, 0, 1'b0));
    ram_ce_in = 1'b0;
    repeat (3) @(posedge clk_in);
    sb_q.delete();
    pushed    = 0;
    started   = 0;
    model_ovf = 1'b0;
    tb_baud   = 4;
    @(negedge clk_in);
    #1;
    reset_in = 1'b1;
    rd(BASE + 32'h8, v);  chk("baud_after_rereset", v, 32'h0000_0004);
    repeat (100) @(posedge clk_in);
    #1;
    chk("no_residual_frame", 32'(started), 32'd0);
    chk("post_reset_tx_high", 32'(tx_out), 32'd1);
    chk("post_reset_busy_low", 32'(tx_busy_out), 32'd0);
    rd(BASE + 32'h4, v);  chk("post_reset_status", v, exp_status(1'b0, 0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
